// File: rtl/serv_immenc_pkg.sv
// Shared definitions for the immediate encoder: format codes, field masks,
// FSM state encoding and the format-normalisation helper.
package serv_immenc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;

  // Unused format codes 5..7 collapse onto the I format.
  function automatic logic [2:0] fmt_norm(input logic [2:0] fmt);
    logic [2:0] res;
    if (fmt > FMT_J) begin
      res = FMT_I;
    end else begin
      res = fmt;
    end
    return res;
  endfunction

endpackage

// File: rtl/serv_immenc_scatter.sv
// Combinational scatter of a 32-bit immediate into the immediate field of an
// instruction word, plus the representability check for the chosen format.
module serv_immenc_scatter
  import serv_immenc_pkg::*;
#(
  parameter int CHECK = 1
) (
  input  logic [2:0]  fmt_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] insn_o,
  output logic        err_o
);

  logic [31:0] scat_s;
  logic [31:0] mask_s;
  logic        rng_s;

  // Field placement and range check per format; default is the I format.
  always_comb begin
    scat_s = 32'd0;
    mask_s = MASK_I;
    rng_s  = 1'b0;
    case (fmt_norm(fmt_i))
      FMT_S: begin
        scat_s = {imm_i[11:5], 13'd0, imm_i[4:0], 7'd0};
        mask_s = MASK_S;
        rng_s  = (imm_i[31:12] != {20{imm_i[11]}});
      end
      FMT_B: begin
        scat_s = {imm_i[12], imm_i[10:5], 13'd0, imm_i[4:1], imm_i[11], 7'd0};
        mask_s = MASK_B;
        rng_s  = imm_i[0] | (imm_i[31:13] != {19{imm_i[12]}});
      end
      FMT_U: begin
        scat_s = {imm_i[31:12], 12'd0};
        mask_s = MASK_U;
        rng_s  = |imm_i[11:0];
      end
      FMT_J: begin
        scat_s = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'd0};
        mask_s = MASK_J;
        rng_s  = imm_i[0] | (imm_i[31:21] != {11{imm_i[20]}});
      end
      default: begin
        scat_s = {imm_i[11:0], 20'd0};
        mask_s = MASK_I;
        rng_s  = (imm_i[31:12] != {20{imm_i[11]}});
      end
    endcase
  end

  assign insn_o = (base_i & ~mask_s) | scat_s;
  assign err_o  = (CHECK != 0) ? rng_s : 1'b0;

endmodule

// File: rtl/serv_immenc.sv
// Immediate encoder: collects a bit-serial immediate (LSB first, W bits per beat)
// and emits a base instruction word with the immediate scattered into it.
module serv_immenc
  import serv_immenc_pkg::*;
#(
  parameter int W     = 1,
  parameter int CHECK = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stb,
  output logic          o_ready,
  input  logic [2:0]    i_fmt,
  input  logic [31:0]   i_base,
  input  logic          i_imm_vld,
  input  logic [W-1:0]  i_imm,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [31:0]   o_insn,
  output logic          o_err
);

  localparam int NB = 32 / W;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  state_e        state_q;
  logic          ready_q;
  logic          vld_q;
  logic          err_q;
  logic [31:0]   insn_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   imm_q;
  logic [31:0]   imm_d;
  logic [2:0]    fmt_q;
  logic [31:0]   base_q;
  logic [31:0]   insn_s;
  logic          err_s;

  // Next shift-register value: the new beat enters at the top and slides down.
  always_comb begin
    imm_d = imm_q;
    if ((state_q == ST_SHIFT) && i_imm_vld) begin
      imm_d = {i_imm, imm_q[31:W]};
    end else begin
      imm_d = imm_q;
    end
  end

  // Encoding is evaluated on the post-shift value so it can be captured on the last beat.
  serv_immenc_scatter #(
    .CHECK (CHECK)
  ) u_scatter (
    .fmt_i  (fmt_q),
    .imm_i  (imm_d),
    .base_i (base_q),
    .insn_o (insn_s),
    .err_o  (err_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      insn_q  <= 32'd0;
      cnt_q   <= '0;
      imm_q   <= 32'd0;
      fmt_q   <= 3'd0;
      base_q  <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_stb) begin
            fmt_q   <= i_fmt;
            base_q  <= i_base;
            cnt_q   <= '0;
            imm_q   <= 32'd0;
            ready_q <= 1'b0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (i_imm_vld) begin
            imm_q <= imm_d;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              insn_q  <= insn_s;
              err_q   <= err_s;
              vld_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_DONE: begin
          // A start in the same cycle as i_rdy is deliberately dropped: ready is still low.
          if (i_rdy) begin
            insn_q  <= 32'd0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          insn_q  <= 32'd0;
          err_q   <= 1'b0;
          vld_q   <= 1'b0;
          ready_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_vld   = vld_q;
  assign o_insn  = insn_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_serv_immenc.sv
// Directed self-checking bench for serv_immenc, one W=1 and one W=4 instance.
module tb_serv_immenc;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  fmt;
  logic [31:0] base;
  logic        imm_vld;
  logic        rdy;

  logic        stb1, ready1, vld1, err1;
  logic [0:0]  imm1;
  logic [31:0] insn1;

  logic        stb4, ready4, vld4, err4;
  logic [3:0]  imm4;
  logic [31:0] insn4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  serv_immenc #(.W(1), .CHECK(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_stb(stb1), .o_ready(ready1), .i_fmt(fmt), .i_base(base),
    .i_imm_vld(imm_vld), .i_imm(imm1), .o_vld(vld1), .i_rdy(rdy), .o_insn(insn1), .o_err(err1)
  );

  serv_immenc #(.W(4), .CHECK(1)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_stb(stb4), .o_ready(ready4), .i_fmt(fmt), .i_base(base),
    .i_imm_vld(imm_vld), .i_imm(imm4), .o_vld(vld4), .i_rdy(rdy), .o_insn(insn4), .o_err(err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start1(input logic [2:0] f, input logic [31:0] b);
    stb1 = 1'b1; fmt = f; base = b;
    tick();
    stb1 = 1'b0;
    cyc = 1;
  endtask

  // Send 32 single-bit beats; with gap=1 each beat is preceded by an idle cycle.
  task automatic send1(input logic [31:0] v, input bit gap);
    for (int i = 0; i < 32; i++) begin
      if (gap) begin
        imm_vld = 1'b0;
        tick();
      end
      imm_vld = 1'b1;
      imm1 = v[i];
      if (i == 31) chk("vld_before_last", {31'd0, vld1}, 32'd0);
      tick();
    end
    imm_vld = 1'b0;
  endtask

  task automatic finish1();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("ready_after_rdy", {31'd0, ready1}, 32'd1);
    chk("vld_after_rdy", {31'd0, vld1}, 32'd0);
    chk("insn_zero_idle", insn1, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; stb1 = 1'b0; stb4 = 1'b0; fmt = 3'd0; base = 32'd0;
    imm_vld = 1'b0; imm1 = 1'b0; imm4 = 4'd0; rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready1}, 32'd1);
    chk("rst_vld", {31'd0, vld1}, 32'd0);
    chk("rst_insn", insn1, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_ready4", {31'd0, ready4}, 32'd1);

    // 1: I format, all ones, contiguous beats
    start1(3'd0, 32'h0000_0013);
    chk("ready_low_shift", {31'd0, ready1}, 32'd0);
    send1(32'hFFFF_FFFF, 1'b0);
    chk("t1_vld", {31'd0, vld1}, 32'd1);
    chk("t1_latency", cyc, 32'd33);
    chk("t1_insn", insn1, 32'hFFF0_0013);
    chk("t1_err", {31'd0, err1}, 32'd0);
    finish1();

    // 2: B format
    start1(3'd2, 32'h0000_0063);
    send1(32'h0000_0FFE, 1'b0);
    chk("t2_insn", insn1, 32'h7E00_0FE3);
    chk("t2_err", {31'd0, err1}, 32'd0);
    finish1();

    // 3: U format with non-zero low bits
    start1(3'd3, 32'h0000_0037);
    send1(32'h1234_5678, 1'b0);
    chk("t3_insn", insn1, 32'h1234_5037);
    chk("t3_err", {31'd0, err1}, 32'd1);
    finish1();

    // 4: J format with a gap before every beat; last beat in cycle 64
    start1(3'd4, 32'h0000_006F);
    send1(32'h0000_0800, 1'b1);
    chk("t4_vld", {31'd0, vld1}, 32'd1);
    chk("t4_latency", cyc, 32'd65);
    chk("t4_insn", insn1, 32'h0010_006F);
    chk("t4_err", {31'd0, err1}, 32'd0);
    finish1();

    // 5: reset in the middle of SHIFT
    start1(3'd0, 32'h0000_0013);
    v = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      imm_vld = 1'b1; imm1 = v[i];
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; imm_vld = 1'b0;
    chk("t5_ready", {31'd0, ready1}, 32'd1);
    chk("t5_vld", {31'd0, vld1}, 32'd0);
    start1(3'd0, 32'h0000_0013);
    send1(32'd5, 1'b0);
    chk("t5_insn", insn1, 32'h0050_0013);
    chk("t5_err", {31'd0, err1}, 32'd0);
    finish1();

    // Reserved format code behaves as I; 0x800 is out of 12-bit signed range
    start1(3'd7, 32'h0000_0013);
    send1(32'h0000_0800, 1'b0);
    chk("fmt7_insn", insn1, 32'h8000_0013);
    chk("fmt7_err", {31'd0, err1}, 32'd1);
    finish1();

    // 6: W=4, S format, held result
    v = 32'hFFFF_FFF8;
    stb4 = 1'b1; fmt = 3'd1; base = 32'h0000_2023;
    tick();
    stb4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      imm_vld = 1'b1; imm4 = v[4*i +: 4];
      tick();
    end
    imm_vld = 1'b0;
    chk("t6_vld", {31'd0, vld4}, 32'd1);
    chk("t6_insn", insn4, 32'hFE00_2C23);
    chk("t6_err", {31'd0, err4}, 32'd0);
    stb4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold_insn", insn4, 32'hFE00_2C23);
      chk("t6_hold_ready", {31'd0, ready4}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0; stb4 = 1'b0;
    chk("t6_ready_after", {31'd0, ready4}, 32'd1);
    chk("t6_vld_after", {31'd0, vld4}, 32'd0);
    tick();
    chk("t6_start_dropped", {31'd0, ready4}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
